// File: rtl/sparse_act_gather.sv
// Purpose : 2:4 sparse activation gather (mode=0) or dense half-split (mode=1) into one output register.
// Latency : 1 cycle from input acceptance to out_valid; a dense beat emits two back-to-back output beats.
// Backpr. : in_ready = 1 when empty, = out_ready when holding one beat, = 0 while a dense high half is pending.
// Ports   : clk/rst_n; mode, in_valid/in_ready, act, sel (input beat);
//           out_valid/out_ready, out_data, out_idx_err (output beat); out_beat_cnt (accepted output beats).
module sparse_act_gather #(
  parameter int DATA_W = 8,
  parameter int GROUPS = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [GROUPS*4*DATA_W-1:0] act,
  input  logic [GROUPS*4-1:0]        sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GROUPS*2*DATA_W-1:0] out_data,
  output logic                       out_idx_err,
  output logic [CNT_W-1:0]           out_beat_cnt
);

  localparam int OUT_W = GROUPS * 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULL    = 2'd1,
    HI_PEND = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] sparse_beat;
  logic [OUT_W-1:0] lo_beat;
  logic [OUT_W-1:0] hi_beat;
  logic [OUT_W-1:0] hi_hold;
  logic             sparse_err;
  logic             in_acc;
  logic             out_acc;

  // Candidate output beats for the current input; only one is captured, at acceptance.
  // Slot s = 2g+k sits at [(2*GROUPS-1-s)*DATA_W], so group 0 slot 0 is the MSB lane.
  always_comb begin
    int idx0;
    int idx1;
    sparse_beat = '0;
    lo_beat     = '0;
    hi_beat     = '0;
    sparse_err  = 1'b0;
    idx0        = 0;
    idx1        = 0;
    for (int g = 0; g < GROUPS; g++) begin
      idx0 = int'(sel[4*g +: 2]);
      idx1 = int'(sel[4*g+2 +: 2]);
      sparse_beat[(2*GROUPS-1-2*g)*DATA_W +: DATA_W] = act[(4*g+idx0)*DATA_W +: DATA_W];
      sparse_beat[(2*GROUPS-2-2*g)*DATA_W +: DATA_W] = act[(4*g+idx1)*DATA_W +: DATA_W];
      lo_beat[(2*GROUPS-1-2*g)*DATA_W +: DATA_W]     = act[(4*g+0)*DATA_W +: DATA_W];
      lo_beat[(2*GROUPS-2-2*g)*DATA_W +: DATA_W]     = act[(4*g+1)*DATA_W +: DATA_W];
      hi_beat[(2*GROUPS-1-2*g)*DATA_W +: DATA_W]     = act[(4*g+2)*DATA_W +: DATA_W];
      hi_beat[(2*GROUPS-2-2*g)*DATA_W +: DATA_W]     = act[(4*g+3)*DATA_W +: DATA_W];
      // Out-of-order or duplicate indices are flagged, but the gather still happens as indexed.
      if (idx0 >= idx1) sparse_err = 1'b1;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      FULL:    in_ready = out_ready;
      HI_PEND: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  // An input can only be accepted in IDLE or in FULL while the held beat drains,
  // so a new load always takes priority over the drain-to-idle path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx_err  <= 1'b0;
      out_beat_cnt <= '0;
      hi_hold      <= '0;
    end else begin
      if (out_acc) out_beat_cnt <= out_beat_cnt + CNT_W'(1);

      if (in_acc) begin
        out_valid <= 1'b1;
        if (mode) begin
          out_data    <= lo_beat;
          hi_hold     <= hi_beat;
          out_idx_err <= 1'b0;
          state       <= HI_PEND;
        end else begin
          out_data    <= sparse_beat;
          out_idx_err <= sparse_err;
          state       <= FULL;
        end
      end else if (out_acc) begin
        if (state == HI_PEND) begin
          // Low half taken: present the high half on the same edge, no bubble.
          out_data    <= hi_hold;
          out_idx_err <= 1'b0;
          state       <= FULL;
        end else begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_act_gather.sv
// Purpose : self-checking bench for sparse_act_gather (DATA_W=8, GROUPS=2, CNT_W=4).
// Latency : expected beats are queued at input acceptance and compared while presented.
// Backpr. : random and directed out_ready stalls; in_ready predicted from queue occupancy.
module tb_sparse_act_gather;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] act;
  logic [7:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_idx_err;
  logic [3:0]  out_beat_cnt;

  sparse_act_gather #(.DATA_W(8), .GROUPS(2), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .act          (act),
    .sel          (sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx_err  (out_idx_err),
    .out_beat_cnt (out_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t q[$];
  int    cnt;
  int    errors;
  int    checks;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [63:0] a, input int g, input int e);
    return 8'((a >> (8 * (4 * g + e))) & 64'hFF);
  endfunction

  // Expected beats for one accepted input, built slot by slot from group 0 downwards.
  task automatic push_expected(input logic m, input logic [63:0] a, input logic [7:0] s);
    beat_t b;
    if (m) begin
      b.e = 1'b0;
      b.d = {elem(a, 0, 0), elem(a, 0, 1), elem(a, 1, 0), elem(a, 1, 1)};
      q.push_back(b);
      b.d = {elem(a, 0, 2), elem(a, 0, 3), elem(a, 1, 2), elem(a, 1, 3)};
      q.push_back(b);
    end else begin
      b.d = 32'h0;
      b.e = 1'b0;
      for (int g = 0; g < 2; g++) begin
        int i0 = int'((s >> (4 * g)) & 8'h3);
        int i1 = int'((s >> (4 * g + 2)) & 8'h3);
        b.d = (b.d << 8) | 32'(elem(a, g, i0));
        b.d = (b.d << 8) | 32'(elem(a, g, i1));
        if (i0 >= i1) b.e = 1'b1;
      end
      q.push_back(b);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic exp_ir;
    logic ia;
    logic oa;
    #1;
    exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, exp_ir);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_idx_err", out_idx_err, q[0].e);
    end
    chk("out_beat_cnt", out_beat_cnt, cnt % 16);
    ia = in_valid && exp_ir;
    oa = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (oa) begin
      void'(q.pop_front());
      cnt++;
    end
    if (ia) push_expected(mode, act, sel);
    @(negedge clk);
  endtask

  logic [3:0] c0;

  initial begin
    errors    = 0;
    checks    = 0;
    cnt       = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    act       = 64'h0;
    sel       = 8'h0;

    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_idx_err", out_idx_err, 1'b0);
    chk("rst_out_beat_cnt", out_beat_cnt, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Sparse gather with legal indices.
    mode = 1'b0; act = 64'h8877665544332211; sel = 8'hD8; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("sparse_data", out_data, 32'h11336688);
    chk("sparse_err", out_idx_err, 1'b0);
    cycle();

    // Illegal group-0 indices (2,2), loaded as the previous beat drains.
    sel = 8'hDA; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("illegal_slots01", out_data[31:16], 16'h3333);
    chk("illegal_err", out_idx_err, 1'b1);
    out_ready = 1'b1;
    cycle();

    // Dense split, streaming.
    c0 = out_beat_cnt;
    mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("dense_lo", out_data, 32'h11225566);
    chk("dense_lo_in_ready", in_ready, 1'b0);
    cycle();
    chk("dense_hi", out_data, 32'h33447788);
    chk("dense_hi_err", out_idx_err, 1'b0);
    cycle();
    chk("dense_cnt_adv", out_beat_cnt - c0, 4'd2);

    // Backpressure: 5 stalled cycles with a waiting input, then 4 beats back to back.
    mode = 1'b0; sel = 8'hD8; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    act = 64'hF0E0D0C0B0A09080; sel = 8'hE4;
    for (int i = 0; i < 5; i++) cycle();
    chk("stall_data", out_data, 32'h11336688);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      act = {$urandom, $urandom};
      sel = 8'($urandom);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Reset while the dense high half is pending.
    mode = 1'b1; act = 64'h8877665544332211; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("hipend_lo_shown", out_data, 32'h11225566);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_cnt", out_beat_cnt, 4'h0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_data", out_data, 32'h0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Counter wrap: 17 accepted output beats on a 4-bit counter.
    mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      act = {$urandom, $urandom};
      sel = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("cnt_wrap", out_beat_cnt, 4'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 2) == 0);
      act       = {$urandom, $urandom};
      sel       = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparse_act_gather.md
SPARSE_ACT_GATHER -- requirements
Module: sparse_act_gather

Interface
REQ-001 SHALL have parameter DATA_W, default 8, activation element width in bits.
REQ-002 SHALL have parameter GROUPS, default 2, number of 4-element activation groups per beat.
REQ-003 SHALL have parameter CNT_W, default 16, width of the output beat counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  1  operating mode: 0 = sparse 2:4 gather, 1 = dense split.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block can accept an input beat.
REQ-009 SHALL have port act  input  GROUPS*4*DATA_W  activations; group g element e at bits [(4g+e)*DATA_W +: DATA_W].
REQ-010 SHALL have port sel  input  GROUPS*4  per-group indices; group g idx0 = sel[4g+1:4g], idx1 = sel[4g+3:4g+2].
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts output beat.
REQ-013 SHALL have port out_data  output  GROUPS*2*DATA_W  gathered activations; slot s = 2g+k placed at bits [(2*GROUPS-1-s)*DATA_W +: DATA_W], so group 0 slot 0 is most significant.
REQ-014 SHALL have port out_idx_err  output  1  current output beat had at least one group with idx0 >= idx1 in sparse mode.
REQ-015 SHALL have port out_beat_cnt  output  CNT_W  count of output beats accepted (out_valid & out_ready).

Function
REQ-016 SHALL transfer an input beat only when in_valid & in_ready are both high on a clock edge, and an output beat only when out_valid & out_ready are both high on a clock edge.
REQ-017 SHALL implement FSM states IDLE (output register empty), FULL (output holding a beat, nothing pending) and HI_PEND (dense mode, output holding the low half, high half stored internally).
REQ-018 SHALL drive in_ready = 1 in IDLE, in_ready = out_ready in FULL, and in_ready = 0 in HI_PEND.
REQ-019 SHALL sample mode, act and sel only at input acceptance; changes at other times have no effect.
REQ-020 In sparse mode, SHALL load the output register with group g slot 0 = element idx0 and slot 1 = element idx1, for every g; out_valid asserts the cycle after acceptance (latency 1).
REQ-021 In sparse mode, SHALL set out_idx_err for the beat if any group has idx0 >= idx1, and SHALL still gather the indexed elements unchanged.
REQ-022 In dense mode, SHALL emit two output beats per input beat: first slots = elements 0,1 of each group, then slots = elements 2,3 of each group; sel is ignored and out_idx_err = 0.
REQ-023 Dense mode: on acceptance, go to HI_PEND; when the low beat is accepted, load the high beat the same edge and go to FULL, with no bubble.
REQ-024 FULL with output accepted and a new input accepted on the same edge: load the new beat, stay FULL (sparse) or go to HI_PEND (dense); throughput one beat per cycle.
REQ-025 FULL with output accepted and no new input: go to IDLE, out_valid = 0 next cycle.
REQ-026 SHALL hold out_data, out_valid and out_idx_err stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL increment out_beat_cnt by 1 per accepted output beat, wrapping from 2^CNT_W-1 to 0.
REQ-028 SHALL be correct for any GROUPS >= 1 and DATA_W >= 1 without RTL edits.

Reset
REQ-029 On rst_n low, SHALL immediately force state IDLE, out_valid = 0, out_data = 0, out_idx_err = 0, out_beat_cnt = 0, pending high half cleared; in_ready = 1 after reset.
REQ-030 Reset asserted mid-operation (including HI_PEND) SHALL discard any held or pending beat; no output beat is produced for it after release.

Verification
REQ-031 Sparse gather: DATA_W=8, GROUPS=2, act group0 = {0x44,0x33,0x22,0x11} (e3..e0), group1 = {0x88,0x77,0x66,0x55}, sel = 0xD8 (g0 idx0=0, idx1=2; g1 idx0=1, idx1=3) -> next cycle out_data = 0x11_33_66_88, out_idx_err = 0.
REQ-032 Illegal indices: same act, sel group0 idx0=2, idx1=2 -> out_data slots 0,1 = 0x33,0x33, out_idx_err = 1.
REQ-033 Dense split with out_ready=1: one input beat -> two consecutive output beats 0x11_22_55_66 then 0x33_44_77_88; in_ready = 0 during the first; out_beat_cnt advances by 2.
REQ-034 Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_data stable, in_ready = 0, no input lost; then out_ready = 1 streams 4 sparse beats in 4 cycles, in order.
REQ-035 Reset in HI_PEND: assert rst_n = 0 after low beat shown -> out_valid = 0 asynchronously, out_beat_cnt = 0, high half never emitted after release.
REQ-036 Counter wrap: CNT_W=4, accept 17 output beats -> out_beat_cnt = 1.
